// File: rtl/voice_sequencer.sv
// Voice sequencer: sweeps NUM_VOICES oscillators on each 48 kHz tick and issues right/left wavetable strobes.
// Optional build macro: VOICE_SEQ_SKIP_IDLE_EN (gated-off voices take a single cycle instead of four).
module voice_sequencer #(
    parameter int NUM_VOICES = 8,
    parameter int PHASE_W    = 24
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          tick48k,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [1:0]                    cfg_sel,
    input  logic [PHASE_W-1:0]            cfg_data,
    output logic [9:0]                    wavetable_r,
    output logic                          wavetable_r_valid,
    output logic [9:0]                    wavetable_l,
    output logic                          wavetable_l_valid,
    output logic [17:0]                   volume,
    output logic                          busy,
    output logic [7:0]                    overrun_count
);

    localparam int VW = $clog2(NUM_VOICES);
    localparam logic [VW-1:0] LAST_V = VW'(NUM_VOICES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SLOT0 = 3'd1,
        ST_SLOT1 = 3'd2,
        ST_SLOT2 = 3'd3,
        ST_SLOT3 = 3'd4
    } state_t;

    logic [PHASE_W-1:0]    phase_q [NUM_VOICES];
    logic [PHASE_W-1:0]    inc_q   [NUM_VOICES];
    logic [17:0]           vol_q   [NUM_VOICES];
    logic [9:0]            off_q   [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q;

    state_t               state_q, state_d;
    logic [VW-1:0]        v_q, v_d;

    // Per-voice working copy taken on SLOT0 entry so mid-slot writes only affect the next sweep
    logic                 snap_gate_q;
    logic [9:0]           snap_addr_q;
    logic [PHASE_W-1:0]   snap_inc_q;
    logic [9:0]           snap_off_q;

    logic [9:0]           wt_r_q, wt_l_q;
    logic                 r_valid_q, l_valid_q;
    logic [17:0]          volume_q;
    logic                 busy_q;
    logic [7:0]           ovr_q;

    logic                 abort_s;
    logic                 step_phase_s;
    logic                 note_on_s;

    assign note_on_s = cfg_we && (cfg_sel == 2'd2) && cfg_data[0] && !gate_q[cfg_voice];

    // Next-state and voice-index logic for the sweep FSM
    always_comb begin
        state_d      = state_q;
        v_d          = v_q;
        abort_s      = 1'b0;
        step_phase_s = 1'b0;
        if (tick48k && (state_q != ST_IDLE)) begin
            abort_s = 1'b1;
            state_d = ST_SLOT0;
            v_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick48k) begin
                        state_d = ST_SLOT0;
                        v_d     = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_SLOT0: begin
`ifdef VOICE_SEQ_SKIP_IDLE_EN
                    if (snap_gate_q) begin
                        state_d = ST_SLOT1;
                    end else if (v_q == LAST_V) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SLOT0;
                        v_d     = v_q + VW'(1);
                    end
`else
                    state_d = ST_SLOT1;
`endif
                end
                ST_SLOT1: state_d = ST_SLOT2;
                ST_SLOT2: state_d = ST_SLOT3;
                ST_SLOT3: begin
                    step_phase_s = snap_gate_q;
                    if (v_q == LAST_V) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_SLOT0;
                        v_d     = v_q + VW'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    v_d     = '0;
                end
            endcase
        end
    end

    // Register file: config writes, phase advance, note-on clear (the clear is last so it wins)
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                inc_q[i]   <= '0;
                vol_q[i]   <= '0;
                off_q[i]   <= '0;
            end
            gate_q <= '0;
        end else begin
            if (step_phase_s) begin
                phase_q[v_q] <= phase_q[v_q] + snap_inc_q;
            end
            if (cfg_we) begin
                case (cfg_sel)
                    2'd0: inc_q[cfg_voice] <= cfg_data;
                    2'd1: vol_q[cfg_voice] <= cfg_data[17:0];
                    2'd2: begin
                        gate_q[cfg_voice] <= cfg_data[0];
                        if (note_on_s) begin
                            phase_q[cfg_voice] <= '0;
                        end
                    end
                    2'd3: off_q[cfg_voice] <= cfg_data[9:0];
                    default: ;
                endcase
            end
        end
    end

    // FSM state, snapshots and registered outputs; strobes are decided from the state being entered
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            v_q         <= '0;
            snap_gate_q <= 1'b0;
            snap_addr_q <= '0;
            snap_inc_q  <= '0;
            snap_off_q  <= '0;
            wt_r_q      <= '0;
            wt_l_q      <= '0;
            r_valid_q   <= 1'b0;
            l_valid_q   <= 1'b0;
            volume_q    <= '0;
            busy_q      <= 1'b0;
            ovr_q       <= '0;
        end else begin
            state_q   <= state_d;
            v_q       <= v_d;
            busy_q    <= (state_d != ST_IDLE);
            r_valid_q <= 1'b0;
            l_valid_q <= 1'b0;
            if (abort_s && (ovr_q != 8'hFF)) begin
                ovr_q <= ovr_q + 8'd1;
            end
            if (state_d == ST_SLOT0) begin
                snap_gate_q <= gate_q[v_d];
                snap_addr_q <= phase_q[v_d][PHASE_W-1 -: 10];
                snap_inc_q  <= inc_q[v_d];
                snap_off_q  <= off_q[v_d];
                if (gate_q[v_d]) begin
                    r_valid_q <= 1'b1;
                    wt_r_q    <= phase_q[v_d][PHASE_W-1 -: 10];
                end
`ifdef VOICE_SEQ_SKIP_IDLE_EN
                if (gate_q[v_d]) begin
                    volume_q <= vol_q[v_d];
                end
`else
                volume_q <= vol_q[v_d];
`endif
            end
            if ((state_d == ST_SLOT2) && snap_gate_q) begin
                l_valid_q <= 1'b1;
                wt_l_q    <= snap_addr_q + snap_off_q;
            end
        end
    end

    assign wavetable_r       = wt_r_q;
    assign wavetable_r_valid = r_valid_q;
    assign wavetable_l       = wt_l_q;
    assign wavetable_l_valid = l_valid_q;
    assign volume            = volume_q;
    assign busy              = busy_q;
    assign overrun_count     = ovr_q;

endmodule

// File: doc/voice_sequencer.md
# voice_sequencer

Sequencer that drives the soundgen wavetable/DCA/mixer path. Holds NUM_VOICES oscillators (phase accumulator, increment, volume, gate, left-channel offset). On every 48 kHz tick it sweeps all voices and issues one right-channel and one left-channel wavetable read strobe per active voice, with the matching volume, so soundgen accumulates the mix before the next tick. Configuration is written by the MIDI decode logic through a simple register-write port.

## Interface
- NUM_VOICES, 8, number of voices; power of two, 2..16
- PHASE_W, 24, phase accumulator width; wavetable address = phase[PHASE_W-1 -: 10]
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- tick48k  input  1  one-cycle sample strobe, same signal soundgen receives
- cfg_we  input  1  register write strobe
- cfg_voice  input  log2(NUM_VOICES)  target voice
- cfg_sel  input  2  0=phase increment, 1=volume, 2=gate (bit0), 3=left offset
- cfg_data  input  PHASE_W  write data, LSB-aligned (volume uses [17:0], offset uses [9:0])
- wavetable_r  output  10  right-channel wavetable address
- wavetable_r_valid  output  1  right read strobe, one cycle
- wavetable_l  output  10  left-channel wavetable address
- wavetable_l_valid  output  1  left read strobe, one cycle
- volume  output  18  envelope for the voice currently in its slot
- busy  output  1  sweep in progress
- overrun_count  output  8  saturating count of ticks arriving while busy

## Operation
- Reset: all outputs 0; all phase, increment, volume, gate, offset registers 0; FSM in IDLE.
- FSM states: IDLE, SLOT0, SLOT1, SLOT2, SLOT3. Voice index v counts within the sweep.
- IDLE + tick48k: v<=0, go to SLOT0 next cycle (or skip rule below), busy<=1.
- SLOT0: if gate[v]: wavetable_r=phase[v][top10], wavetable_r_valid=1. volume=vol[v] (registered, held until next SLOT0 or reset).
- SLOT1: no strobe.
- SLOT2: if gate[v]: wavetable_l=(phase[v][top10]+offset[v]) mod 1024, wavetable_l_valid=1.
- SLOT3: if gate[v]: phase[v]<=phase[v]+inc[v] mod 2^PHASE_W. If v==NUM_VOICES-1: IDLE, busy<=0; else v<=v+1, SLOT0.
- Addresses hold their last value when valid is low. r and l strobes never in the same cycle.
- Gate 0->1 write clears phase[v] to 0 (note-on restart). Gate 1->0 keeps phase. Gate write 1->1 no effect on phase.
- Config writes update the register file in the cycle after cfg_we. Writes to voice v during its slot: increment/volume/offset take effect at the next sweep (values captured at SLOT0); gate change during SLOT0..SLOT3 of that voice takes effect next sweep.
- Write with cfg_we and the voice's SLOT3 phase update same cycle on a gate 0->1: clear wins.
- tick48k while busy: abort sweep (no further strobes this cycle onward), overrun_count+1 saturating at 255, restart at v=0 SLOT0 next cycle.

## Timing
- tick48k high at cycle T -> voice 0 SLOT0 at T+1; voice v SLOT0 at T+1+4v (deterministic mode).
- Full sweep = 4*NUM_VOICES cycles; busy high T+1 .. T+4*NUM_VOICES inclusive.
- Strobe-to-soundgen: soundgen mixes at strobe+1; last left strobe at T+4N-1 mixes at T+4N, before any legal next tick (clocks per tick > 4N+1 required at system level).
- Config write latency 1 cycle; no backpressure; cfg_we ignored during rst.
- rst mid-sweep: next cycle all outputs 0, FSM IDLE, registers cleared.

## Configuration
- VOICE_SEQ_SKIP_IDLE_EN defined: voices with gate=0 consume one cycle (SLOT0 only, no strobe, volume not updated), then advance; sweep length = 4*(active voices) + (idle voices).
- Undefined: every voice consumes a full 4-cycle slot regardless of gate; sweep timing fixed at 4*NUM_VOICES cycles.

## Test plan
- Reset then tick, all gates 0 -> no valid strobes, busy high 32 cycles (default build), volume stays 0.
- Voice 2: inc=0x010000, vol=0x1FFFF, gate=1, offset=0x010; three ticks -> r strobes at T+9 with addr 0x000, 0x004, 0x008; l strobes at T+11 with 0x010, 0x014, 0x018; volume 0x1FFFF during slot 2.
- Wrap: voice 0 phase near 0xFFFFFF, inc=0x000100, offset=0x3FF -> phase wraps to 0x0000FF, left address wraps mod 1024.
- Second tick 10 cycles after first -> overrun_count=1, sweep restarts at voice 0, no strobe from aborted voice after tick; 300 overruns -> count 255.
- Gate 0->1 on voice with phase 0x123456 -> phase 0, first r addr 0x000; gate 1->0->1 via writes during its SLOT2 -> current sweep unaffected.
- VOICE_SEQ_SKIP_IDLE_EN, only voice 7 active -> its SLOT0 at T+8, busy low after T+11; rst asserted at T+9 -> all outputs 0 at T+10.
